// File: rtl/asip_data_mem.sv
// Data-memory responder for the ASIP load/store port: one request at a time,
// WAIT_CYCLES wait states, then a one-cycle ack carrying read data or a range error.
module asip_data_mem #(
    parameter int DATA_W      = 17,
    parameter int ADDR_W      = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [DATA_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ack,
    output logic              mem_err,
    output logic              mem_busy
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] CNT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state, state_nxt;
    logic [3:0]        cnt, cnt_nxt;
    logic              req_we;
    logic [DATA_W-1:0] req_addr, req_wdata;
    logic              err_q;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              cur_we;
    logic [DATA_W-1:0] cur_addr, cur_wdata;
    logic              out_of_range;
    logic [ADDR_W-1:0] idx;
    logic              enter_resp;

    // With zero wait states RESP is entered on the accept edge itself, so the
    // live request must be used before the latched copy exists.
    always_comb begin
        cur_we    = req_we;
        cur_addr  = req_addr;
        cur_wdata = req_wdata;
        if (state == IDLE) begin
            cur_we    = mem_we;
            cur_addr  = mem_addr;
            cur_wdata = mem_wdata;
        end
    end

    assign out_of_range = |cur_addr[DATA_W-1:ADDR_W];
    assign idx          = cur_addr[ADDR_W-1:0];
    assign enter_resp   = (state_nxt == RESP);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (mem_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            err_q     <= 1'b0;
            mem_rdata <= '0;
            req_we    <= 1'b0;
            req_addr  <= '0;
            req_wdata <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && mem_req) begin
                req_we    <= mem_we;
                req_addr  <= mem_addr;
                req_wdata <= mem_wdata;
            end
            if (enter_resp) begin
                err_q <= out_of_range;
                if (!cur_we) mem_rdata <= out_of_range ? '0 : mem[idx];
            end
        end
    end

    // Array is never cleared; reset only suppresses an uncommitted store.
    always_ff @(posedge clk) begin
        if (reset && enter_resp && cur_we && !out_of_range)
            mem[idx] <= cur_wdata;
    end

    assign mem_ack  = (state == RESP);
    assign mem_err  = (state == RESP) && err_q;
    assign mem_busy = (state != IDLE);

endmodule

// File: tb/tb_asip_data_mem.sv
module tb_asip_data_mem;

    localparam int WC = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req, mem_we;
    logic [16:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack, mem_err, mem_busy;

    int n_pass = 0;
    int n_total = 0;

    asip_data_mem #(.DATA_W(17), .ADDR_W(8), .WAIT_CYCLES(WC)) dut (
        .clk(clk), .reset(reset), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .mem_err(mem_err), .mem_busy(mem_busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [16:0] addr;
        logic [16:0] wdata;
        logic        chk_rd;
        logic [16:0] exp_rd;
        logic        exp_err;
    } vec_t;

    logic [16:0] model [256];
    logic [16:0] last_rd;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    endtask

    // Issue one access from an IDLE cycle; returns cycles from accept to ack
    // (ack cycle counted, -1 if no ack), read data and error seen with the ack.
    task automatic access(input logic we, input logic [16:0] addr, input logic [16:0] wdata,
                          output int lat, output logic [16:0] rd, output logic er,
                          output logic busy1);
        mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        @(posedge clk); #1;
        busy1 = mem_busy;
        lat = -1; rd = '0; er = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            if (mem_ack) begin
                lat = n; rd = mem_rdata; er = mem_err;
                break;
            end
            @(posedge clk); #1;
        end
        mem_req = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t tbl [8];
        int lat;
        logic [16:0] rd;
        logic er, b1;
        int acks [$];

        reset = 1'b0; mem_req = 1'b0; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_ack", mem_ack, 0);
        check("rst_err", mem_err, 0);
        check("rst_busy", mem_busy, 0);
        check("rst_rdata", mem_rdata, 0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Known contents everywhere so every later read is predictable.
        for (int i = 0; i < 256; i++) begin
            model[i] = 17'(i * 3 + 1);
            access(1'b1, 17'(i), model[i], lat, rd, er, b1);
        end
        last_rd = '0;

        tbl[0] = '{1'b1, 17'd7,       17'd2,       1'b0, 17'd0,       1'b0};
        tbl[1] = '{1'b0, 17'd7,       17'd0,       1'b1, 17'd2,       1'b0};
        tbl[2] = '{1'b0, 17'h00100,   17'd0,       1'b1, 17'd0,       1'b1};
        tbl[3] = '{1'b0, 17'd0,       17'd0,       1'b1, 17'd1,       1'b0};
        tbl[4] = '{1'b1, 17'h1FFFF,   17'd5,       1'b0, 17'd0,       1'b1};
        tbl[5] = '{1'b0, 17'd255,     17'd0,       1'b1, 17'd766,     1'b0};
        tbl[6] = '{1'b1, 17'd255,     17'h1ABCD,   1'b1, 17'd766,     1'b0};
        tbl[7] = '{1'b0, 17'd255,     17'd0,       1'b1, 17'h1ABCD,   1'b0};
        for (int i = 0; i < 8; i++) begin
            access(tbl[i].we, tbl[i].addr, tbl[i].wdata, lat, rd, er, b1);
            check($sformatf("tbl%0d_busy", i), b1, 1);
            check($sformatf("tbl%0d_lat", i), lat, WC + 1);
            check($sformatf("tbl%0d_err", i), er, tbl[i].exp_err);
            if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].exp_rd);
        end
        model[7] = 17'd2;
        model[255] = 17'h1ABCD;
        last_rd = 17'h1ABCD;

        // Read data holds after the response.
        repeat (2) @(posedge clk);
        #1;
        check("rdata_hold", mem_rdata, 17'h1ABCD);

        // Reset during WAIT drops the store.
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 17'd5; mem_wdata = 17'h1ABCD;
        @(posedge clk); #1;
        mem_req = 1'b0;
        check("midrst_busy", mem_busy, 1);
        reset = 1'b0;
        @(posedge clk); #1;
        check("midrst_idle", mem_busy, 0);
        check("midrst_ack", mem_ack, 0);
        check("midrst_rdata", mem_rdata, 0);
        reset = 1'b1;
        repeat (WC + 1) begin
            @(posedge clk); #1;
            check("midrst_noack", mem_ack, 0);
        end
        access(1'b0, 17'd5, 17'd0, lat, rd, er, b1);
        check("midrst_load", rd, model[5]);
        last_rd = model[5];

        // Back-to-back loads with mem_req held; dropped during second WAIT.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 17'd7;
        @(posedge clk); #1;
        for (int n = 1; n <= 14; n++) begin
            if (mem_ack) begin
                acks.push_back(n);
                check("b2b_rdata", mem_rdata, 17'd2);
            end else if (acks.size() == 1 && mem_busy) begin
                mem_req = 1'b0;
            end
            if (acks.size() == 1 && n == acks[0] + 1) check("b2b_idle_gap", mem_busy, 0);
            @(posedge clk); #1;
        end
        mem_req = 1'b0;
        check("b2b_acks", acks.size(), 2);
        if (acks.size() == 2) check("b2b_spacing", acks[1] - acks[0], WC + 2);
        last_rd = 17'd2;

        // Random traffic against the array model.
        for (int t = 0; t < 200; t++) begin
            logic we;
            logic [16:0] a, d;
            logic exp_err;
            we = 1'($urandom_range(0, 1));
            a = 17'($urandom_range(0, 255));
            if (!we && $urandom_range(0, 7) == 0) a = 17'($urandom_range(256, 17'h1FFFF));
            d = 17'($urandom);
            exp_err = (a > 17'd255);
            access(we, a, d, lat, rd, er, b1);
            check("rnd_lat", lat, WC + 1);
            check("rnd_err", er, exp_err);
            if (we) model[a[7:0]] = d;
            else last_rd = exp_err ? 17'd0 : model[a[7:0]];
            check("rnd_rdata", rd, last_rd);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
